// File: rtl/rst_sequencer_if.sv
// rst_sequencer_if: lock/request inputs and staged reset/status outputs of the reset sequencer.
interface rst_sequencer_if #(
    parameter int NUM_STAGES = 3
);
    logic                  locked;
    logic                  sw_rst_req;
    logic [NUM_STAGES-1:0] stage_rst;
    logic                  seq_done;
    logic [2:0]            seq_state;
    logic                  lock_timeout;
    modport master (
        output locked, sw_rst_req,
        input  stage_rst, seq_done, seq_state, lock_timeout
    );
    modport slave (
        input  locked, sw_rst_req,
        output stage_rst, seq_done, seq_state, lock_timeout
    );
endinterface

// File: rtl/rst_sequencer.sv
// rst_sequencer: staged reset release after stable clock lock; optional lock watchdog via RST_SEQ_WATCHDOG_EN.
module rst_sequencer #(
    parameter int NUM_STAGES   = 3,
    parameter int POR_CYCLES   = 200,
    parameter int LOCK_STABLE  = 1024,
    parameter int STAGE_GAP    = 64,
    parameter int CNT_W        = 20,
    parameter int LOCK_TIMEOUT = 1000000
) (
    input logic          fpga_sysclk,
    input logic          reset,
    rst_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        HOLD      = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RELEASE   = 3'd3,
        RUN       = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] POR_T = CNT_W'(POR_CYCLES - 1);
    localparam logic [CNT_W-1:0] LS_T  = CNT_W'(LOCK_STABLE);
    localparam logic [CNT_W-1:0] GAP_T = CNT_W'(STAGE_GAP - 1);

    if (NUM_STAGES < 1 || NUM_STAGES > 8 || STAGE_GAP < 1 || POR_CYCLES < 1 || LOCK_STABLE < 1 ||
        LOCK_TIMEOUT < 1 || longint'(LOCK_TIMEOUT) >= (longint'(1) << CNT_W))
        $error("rst_sequencer: illegal parameter set");

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic [NUM_STAGES-1:0] stage_rst;
    logic [NUM_STAGES-1:0] shifted;
    logic                  seq_done;

    // One more stage released: zeros shift in from bit 0 upward.
    assign shifted = stage_rst << 1;

    always_ff @(posedge fpga_sysclk) begin
        if (reset) begin
            state     <= HOLD;
            cnt       <= '0;
            stage_rst <= '1;
            seq_done  <= 1'b0;
        end else begin
            case (state)
                HOLD: begin
                    state <= (cnt == POR_T) ? WAIT_LOCK : HOLD;
                    cnt   <= (cnt == POR_T) ? '0 : cnt + 1'b1;
                end
                WAIT_LOCK: begin
                    state <= bus.locked ? STABLE : WAIT_LOCK;
                    cnt   <= bus.locked ? CNT_W'(1) : '0;
                end
                STABLE, RELEASE: begin
                    if (!bus.locked) begin
                        // A bounce while counting stability only restarts the count.
                        state     <= (state == STABLE) ? WAIT_LOCK : HOLD;
                        cnt       <= '0;
                        stage_rst <= '1;
                        seq_done  <= 1'b0;
                    end else if (cnt == ((state == STABLE) ? LS_T : GAP_T)) begin
                        state     <= (shifted == '0) ? RUN : RELEASE;
                        cnt       <= '0;
                        stage_rst <= shifted;
                        seq_done  <= (shifted == '0);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (!bus.locked || bus.sw_rst_req) begin
                        state     <= HOLD;
                        stage_rst <= '1;
                        seq_done  <= 1'b0;
                    end
                    cnt <= '0;
                end
                default: begin
                    state     <= HOLD;
                    cnt       <= '0;
                    stage_rst <= '1;
                    seq_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.stage_rst = stage_rst;
    assign bus.seq_done  = seq_done;
    assign bus.seq_state = state;

`ifdef RST_SEQ_WATCHDOG_EN
    localparam logic [CNT_W-1:0] TO_T = CNT_W'(LOCK_TIMEOUT);
    logic [CNT_W-1:0] wd;
    logic             lock_to;
    // Runs across WAIT_LOCK/STABLE bounces so repeated lock glitches still time out.
    always_ff @(posedge fpga_sysclk) begin
        if (reset) begin
            wd      <= '0;
            lock_to <= 1'b0;
        end else begin
            wd      <= (state == WAIT_LOCK || state == STABLE) ? ((wd == TO_T) ? wd : wd + 1'b1) : '0;
            lock_to <= lock_to | (wd == TO_T);
        end
    end
    assign bus.lock_timeout = lock_to;
`else
    assign bus.lock_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_rst_sequencer.sv
// tb_rst_sequencer: directed timeline checks of the staged reset sequencer.
module tb_rst_sequencer;
    localparam int NS = 3;
`ifdef RST_SEQ_WATCHDOG_EN
    localparam logic WD = 1'b1;
`else
    localparam logic WD = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   e;
    int   b;
    int   errors = 0;
    int   checks = 0;

    rst_sequencer_if #(.NUM_STAGES(NS)) bus ();

    rst_sequencer #(
        .NUM_STAGES  (NS),
        .POR_CYCLES  (4),
        .LOCK_STABLE (8),
        .STAGE_GAP   (16),
        .CNT_W       (20),
        .LOCK_TIMEOUT(50)
    ) dut (
        .fpga_sysclk(clk),
        .reset      (reset),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s @edge %0d: observed %0h expected %0h", tag, e, obs, exp);
        end
    endtask

    task automatic adv(input int target);
        while (e < target) begin
            @(posedge clk);
            #1;
            e++;
        end
    endtask

    task automatic at(input int target, input logic [2:0] stg, input logic done, input logic [2:0] st);
        adv(target);
        chk("stage_rst", 32'(bus.stage_rst), 32'(stg));
        chk("seq_done", 32'(bus.seq_done), 32'(done));
        chk("seq_state", 32'(bus.seq_state), 32'(st));
    endtask

    task automatic check_reset_vals();
        chk("rst_stage", 32'(bus.stage_rst), 32'h7);
        chk("rst_done", 32'(bus.seq_done), 32'h0);
        chk("rst_state", 32'(bus.seq_state), 32'h0);
        chk("rst_lto", 32'(bus.lock_timeout), 32'h0);
    endtask

    initial begin
        reset = 1'b1;
        bus.locked = 1'b1;
        bus.sw_rst_req = 1'b0;
        e = 0;
        repeat (10) @(posedge clk);
        #1;
        check_reset_vals();
        reset = 1'b0;
        // Clean bring-up
        at(3, 3'b111, 1'b0, 3'd0);
        at(4, 3'b111, 1'b0, 3'd1);
        at(5, 3'b111, 1'b0, 3'd2);
        at(12, 3'b111, 1'b0, 3'd2);
        at(13, 3'b110, 1'b0, 3'd3);
        at(28, 3'b110, 1'b0, 3'd3);
        at(29, 3'b100, 1'b0, 3'd3);
        at(44, 3'b100, 1'b0, 3'd3);
        at(45, 3'b000, 1'b1, 3'd4);
        // Software request in RUN, plus ignored pulses in HOLD and RELEASE
        adv(50);
        bus.sw_rst_req = 1'b1;
        at(51, 3'b111, 1'b0, 3'd0);
        bus.sw_rst_req = 1'b0;
        b = 51;
        adv(b + 1);
        bus.sw_rst_req = 1'b1;
        adv(b + 2);
        bus.sw_rst_req = 1'b0;
        at(b + 12, 3'b111, 1'b0, 3'd2);
        at(b + 13, 3'b110, 1'b0, 3'd3);
        adv(b + 20);
        bus.sw_rst_req = 1'b1;
        adv(b + 21);
        bus.sw_rst_req = 1'b0;
        at(b + 28, 3'b110, 1'b0, 3'd3);
        at(b + 29, 3'b100, 1'b0, 3'd3);
        at(b + 44, 3'b100, 1'b0, 3'd3);
        at(b + 45, 3'b000, 1'b1, 3'd4);
        // Second sw request, then reset asserted mid-RELEASE
        adv(b + 50);
        bus.sw_rst_req = 1'b1;
        adv(b + 51);
        bus.sw_rst_req = 1'b0;
        b = b + 51;
        at(b + 35, 3'b100, 1'b0, 3'd3);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_reset_vals();
        reset = 1'b0;
        e = 0;
        // Timeline restarts from edge 1; lock glitch sampled at edge 9 in STABLE
        adv(8);
        bus.locked = 1'b0;
        at(9, 3'b111, 1'b0, 3'd1);
        bus.locked = 1'b1;
        at(10, 3'b111, 1'b0, 3'd2);
        at(17, 3'b111, 1'b0, 3'd2);
        at(18, 3'b110, 1'b0, 3'd3);
        // Lock loss mid-RELEASE
        adv(20);
        bus.locked = 1'b0;
        at(21, 3'b111, 1'b0, 3'd0);
        bus.locked = 1'b1;
        at(33, 3'b111, 1'b0, 3'd2);
        at(34, 3'b110, 1'b0, 3'd3);
        at(50, 3'b100, 1'b0, 3'd3);
        at(65, 3'b100, 1'b0, 3'd3);
        at(66, 3'b000, 1'b1, 3'd4);
        // Lock loss in RUN, long unlock period (watchdog window)
        adv(70);
        bus.locked = 1'b0;
        at(71, 3'b111, 1'b0, 3'd0);
        b = 71;
        at(b + 20, 3'b111, 1'b0, 3'd1);
        chk("lto_early", 32'(bus.lock_timeout), 32'h0);
        at(b + 60, 3'b111, 1'b0, 3'd1);
        chk("lto_late", 32'(bus.lock_timeout), 32'(WD));
        bus.locked = 1'b1;
        at(b + 61, 3'b111, 1'b0, 3'd2);
        at(b + 68, 3'b111, 1'b0, 3'd2);
        at(b + 69, 3'b110, 1'b0, 3'd3);
        at(b + 85, 3'b100, 1'b0, 3'd3);
        at(b + 101, 3'b000, 1'b1, 3'd4);
        chk("lto_held", 32'(bus.lock_timeout), 32'(WD));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1, "timeout");
    end
endmodule
